// File: rtl/lsu_pkg.sv
// Shared encodings and decode helpers for the load/store data-memory controller.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_LBU = 3'd3,
    OP_LHU = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  function automatic logic is_store(input op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_misaligned(input op_e op, input logic [1:0] lane);
    case (op)
      OP_LH, OP_LHU, OP_SH: return lane[0];
      OP_LW, OP_SW:         return |lane;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// Byte-lane steering: load extract/extend and sub-word store merge (little-endian).
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (lane)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (op_e'(op))
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'd0, byte_sel};
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'd0, half_sel};
      default: load_data = word;
    endcase

    merged = word;
    case (op_e'(op))
      OP_SB: begin
        case (lane)
          2'd0: merged[7:0]   = wdata[7:0];
          2'd1: merged[15:8]  = wdata[7:0];
          2'd2: merged[23:16] = wdata[7:0];
          2'd3: merged[31:24] = wdata[7:0];
          default: merged = word;
        endcase
      end
      OP_SH: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      OP_SW:   merged = wdata;
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/lsu_dm_ctrl.sv
// MEM-stage load/store initiator for a word-write data memory; sub-word stores use read-modify-write.
// state     | meaning
// ST_IDLE   | ready for a request; decode and error-check it
// ST_ACCESS | memory read (loads, RMW) or whole-word write (SW)
// ST_MERGE  | write back the merged word of an SB/SH
// ST_RESP   | response held until the consumer accepts it
module lsu_dm_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int DM_BYTES = 12288
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic              dm_we,
  input  logic [31:0]       dm_dout
);

  state_e            state, state_nx;
  op_e               op_q, op_nx;
  logic [1:0]        lane_q, lane_nx;
  logic [31:0]       wdata_q, wdata_nx;
  logic [31:0]       rdata_nx;
  logic              err_nx;
  logic              we_nx;
  logic [ADDR_W-1:0] daddr_nx;
  logic [31:0]       din_nx;
  logic              req_err;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  lsu_lane_mux u_lane_mux (
    .op        (op_q),
    .lane      (lane_q),
    .word      (dm_dout),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign req_err   = is_misaligned(op_e'(req_op), req_addr[1:0])
                     || (32'(req_addr) >= 32'(DM_BYTES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    op_nx    = op_q;
    lane_nx  = lane_q;
    wdata_nx = wdata_q;
    rdata_nx = rsp_rdata;
    err_nx   = rsp_err;
    we_nx    = 1'b0;
    daddr_nx = dm_addr;
    din_nx   = dm_din;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          op_nx    = op_e'(req_op);
          lane_nx  = req_addr[1:0];
          wdata_nx = req_wdata;
          rdata_nx = 32'd0;
          err_nx   = req_err;
          if (req_err) begin
            state_nx = ST_RESP;
          end else begin
            state_nx = ST_ACCESS;
            daddr_nx = {req_addr[ADDR_W-1:2], 2'b00};
            // SW needs no read, so its write is armed for the ACCESS cycle
            if (op_e'(req_op) == OP_SW) begin
              we_nx  = 1'b1;
              din_nx = req_wdata;
            end
          end
        end
      end
      ST_ACCESS: begin
        if (!is_store(op_q)) begin
          rdata_nx = load_data;
          state_nx = ST_RESP;
        end else if (op_q == OP_SW) begin
          state_nx = ST_RESP;
        end else begin
          we_nx    = 1'b1;
          din_nx   = merged;
          state_nx = ST_MERGE;
        end
      end
      ST_MERGE: state_nx = ST_RESP;
      ST_RESP:  if (rsp_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // dm_we comes straight from a flop so it cannot glitch; reset drops it at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= OP_LB;
      lane_q    <= 2'd0;
      wdata_q   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      dm_din    <= 32'd0;
    end else begin
      op_q      <= op_nx;
      lane_q    <= lane_nx;
      wdata_q   <= wdata_nx;
      rsp_rdata <= rdata_nx;
      rsp_err   <= err_nx;
      dm_we     <= we_nx;
      dm_addr   <= daddr_nx;
      dm_din    <= din_nx;
    end
  end

endmodule
